car_lane_mover: RTL and testbench
=================================

Name: car_lane_mover

Overview:
- Upstream of the sprite renderer and the car collision checker. Replaces their fixed car coordinates with a moving car.
- Produces the X/Y position of one car on one lane. The car advances horizontally at a rate set by the current level and wraps around the screen edge.
- A small state machine handles idle, running and frozen (for example after a collision) modes.
- One instance per lane; each instance has its own parameters.

Parameters:
- SCREEN_WIDTH, 640: visible width in pixels; legal X range is 0..SCREEN_WIDTH-1.
- LANE_Y, 320: constant Y of the lane (10 tiles of 32 px).
- START_X, 0: X of the car after reset and in IDLE.
- DIRECTION, 0: 0 = move right (X increases), 1 = move left (X decreases).
- STEP_PX, 1: pixels moved per step; 1 <= STEP_PX < SCREEN_WIDTH.
- BASE_TICKS, 250000: clocks per step at level 0.
- LEVEL_DECREMENT, 20000: clocks removed from the period per level.
- MIN_TICKS, 50000: lower clamp on the step period; MIN_TICKS >= 2.

Ports:
- i_Clk, input, 1: system clock.
- i_Reset, input, 1: synchronous, active-high reset.
- i_Enable, input, 1: game running. 1 starts or keeps motion; 0 returns the car to START_X.
- i_Freeze, input, 1: level-sensitive hold, e.g. the collision flag.
- i_Level, input, 4: difficulty level; sets the speed.
- o_Car_X, output, 10: current car X in pixels.
- o_Car_Y, output, 10: car Y; always LANE_Y.
- o_Step, output, 1: one-cycle pulse in the same cycle o_Car_X first shows a new value.
- o_Running, output, 1: 1 while in state RUN.

Behaviour:
- Reset: state = IDLE, o_Car_X = START_X, o_Car_Y = LANE_Y, o_Step = 0, o_Running = 0, tick counter = 0.
  - Reset takes priority over every other input in the same cycle.
  - Reset asserted mid-step discards the partial count.
- Period computation (registered as r_Period):
  - P = BASE_TICKS - i_Level*LEVEL_DECREMENT, computed in 32-bit unsigned arithmetic.
  - If the subtraction underflows, or P < MIN_TICKS, then P = MIN_TICKS.
  - i_Level is sampled only on the IDLE->RUN transition and on every step. A level change takes effect from the next full period and never truncates the period in progress.
- States:
  - IDLE: o_Car_X held at START_X, counter = 0. Go to RUN when i_Enable=1 && i_Freeze=0; latch r_Period at this transition.
  - RUN: counter increments every clock.
    - When counter == r_Period-1: counter <= 0, X updates, o_Step=1 on the following cycle together with the new X, r_Period reloaded from i_Level.
    - i_Freeze=1 -> go to FROZEN. No X update and no o_Step that cycle, even if the counter is at r_Period-1.
    - i_Enable=0 -> go to IDLE with o_Car_X <= START_X. This takes priority over i_Freeze.
  - FROZEN: counter and X held.
    - i_Enable=0 -> IDLE (X <= START_X).
    - i_Freeze=0 with i_Enable=1 -> RUN, resuming the held count with no restart.
- Step arithmetic (11-bit intermediate, result always in 0..SCREEN_WIDTH-1):
  - DIRECTION=0: if X+STEP_PX >= SCREEN_WIDTH then X <= X+STEP_PX-SCREEN_WIDTH, else X <= X+STEP_PX.
  - DIRECTION=1: if X < STEP_PX then X <= X+SCREEN_WIDTH-STEP_PX, else X <= X-STEP_PX.
- Outputs:
  - All outputs are registered; there are no combinational paths from inputs to outputs.
  - o_Step is never high in IDLE or FROZEN, and never high for two consecutive cycles (r_Period >= 2).
  - o_Car_Y is constant LANE_Y in every state, including during reset.

Test Plan:
Bench parameters: SCREEN_WIDTH=16, STEP_PX=3, START_X=0, BASE_TICKS=10, LEVEL_DECREMENT=2, MIN_TICKS=4, DIRECTION=0 unless stated.
- Reset then i_Enable=1, i_Level=0: o_Running rises next cycle; o_Step pulses every 10 clocks; X sequence is 0,3,6,9,12,15,2 (wrap 15+3-16=2).
- i_Level=2, then 5, then 15: periods of 6 and 4 clocks; level 15 (10-30 underflows) clamps to 4. A change from level 0 to level 2 made mid-period leaves the current 10-clock period intact and the next period is 6.
- DIRECTION=1, START_X=1: X sequence is 1,14,11,8,5,2,15 (1<3 so 1+16-3=14).
- i_Freeze=1 asserted on the cycle the counter equals r_Period-1: no o_Step and X unchanged. Release after 20 clocks: the step occurs on the first RUN cycle's completion, and total elapsed counted ticks equal exactly the period.
- i_Enable dropped during RUN with X=9, and again during FROZEN: next cycle X=0, o_Running=0, no o_Step. Re-enable: the first step arrives after a full period.
- i_Reset pulsed for one cycle mid-period while X=12 and i_Freeze=1: outputs return to X=0, o_Step=0, o_Running=0, state IDLE, o_Car_Y=320 (default LANE_Y) throughout.

Source files
------------

// File: rtl/car_lane_mover.sv
// Moving car position generator for one lane: steps X at a level-dependent
// period, wraps at the screen edge, and supports idle/run/frozen modes.
module car_lane_mover #(
    parameter int unsigned SCREEN_WIDTH    = 640,
    parameter int unsigned LANE_Y          = 320,
    parameter int unsigned START_X         = 0,
    parameter bit          DIRECTION       = 1'b0,
    parameter int unsigned STEP_PX         = 1,
    parameter int unsigned BASE_TICKS      = 250000,
    parameter int unsigned LEVEL_DECREMENT = 20000,
    parameter int unsigned MIN_TICKS       = 50000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic       i_Freeze,
    input  logic [3:0] i_Level,
    output logic [9:0] o_Car_X,
    output logic [9:0] o_Car_Y,
    output logic       o_Step,
    output logic       o_Running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN
    } state_t;

    state_t      r_State;
    state_t      w_State_Next;
    logic [31:0] r_Count;
    logic [31:0] w_Count_Next;
    logic [31:0] r_Period;
    logic [31:0] w_Period_Next;
    logic [9:0]  w_X_Next;
    logic        w_Step_Next;
    logic [31:0] w_Level_Dec;
    logic [31:0] w_Level_Period;
    logic [10:0] w_X_Wide;
    logic [10:0] w_Sum;
    logic [9:0]  w_X_Stepped;

    assign o_Car_Y = 10'(LANE_Y);

    // Underflow of the subtraction and a too-short period both clamp to MIN_TICKS.
    always_comb begin
        w_Level_Dec = 32'(i_Level) * LEVEL_DECREMENT;
        if ((w_Level_Dec > BASE_TICKS) || ((BASE_TICKS - w_Level_Dec) < MIN_TICKS))
            w_Level_Period = MIN_TICKS;
        else
            w_Level_Period = BASE_TICKS - w_Level_Dec;
    end

    always_comb begin
        w_X_Wide = {1'b0, o_Car_X};
        if (DIRECTION == 1'b0) begin
            w_Sum = w_X_Wide + 11'(STEP_PX);
            if (w_Sum >= 11'(SCREEN_WIDTH))
                w_Sum = w_Sum - 11'(SCREEN_WIDTH);
        end else begin
            if (w_X_Wide < 11'(STEP_PX))
                w_Sum = w_X_Wide + 11'(SCREEN_WIDTH) - 11'(STEP_PX);
            else
                w_Sum = w_X_Wide - 11'(STEP_PX);
        end
        w_X_Stepped = w_Sum[9:0];
    end

    always_comb begin
        w_State_Next  = r_State;
        w_Count_Next  = r_Count;
        w_Period_Next = r_Period;
        w_X_Next      = o_Car_X;
        w_Step_Next   = 1'b0;
        case (r_State)
            IDLE: begin
                w_X_Next     = 10'(START_X);
                w_Count_Next = '0;
                if (i_Enable && !i_Freeze) begin
                    w_State_Next  = RUN;
                    w_Period_Next = w_Level_Period;
                end
            end
            RUN: begin
                // Disable beats freeze; freeze suppresses a step due this cycle.
                if (!i_Enable) begin
                    w_State_Next = IDLE;
                    w_X_Next     = 10'(START_X);
                    w_Count_Next = '0;
                end else if (i_Freeze) begin
                    w_State_Next = FROZEN;
                end else if (r_Count == r_Period - 32'd1) begin
                    w_Count_Next  = '0;
                    w_X_Next      = w_X_Stepped;
                    w_Step_Next   = 1'b1;
                    w_Period_Next = w_Level_Period;
                end else begin
                    w_Count_Next = r_Count + 32'd1;
                end
            end
            FROZEN: begin
                if (!i_Enable) begin
                    w_State_Next = IDLE;
                    w_X_Next     = 10'(START_X);
                    w_Count_Next = '0;
                end else if (!i_Freeze) begin
                    w_State_Next = RUN;
                end
            end
            default: begin
                w_State_Next = IDLE;
                w_X_Next     = 10'(START_X);
                w_Count_Next = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State   <= IDLE;
            r_Count   <= '0;
            r_Period  <= MIN_TICKS;
            o_Car_X   <= 10'(START_X);
            o_Step    <= 1'b0;
            o_Running <= 1'b0;
        end else begin
            r_State   <= w_State_Next;
            r_Count   <= w_Count_Next;
            r_Period  <= w_Period_Next;
            o_Car_X   <= w_X_Next;
            o_Step    <= w_Step_Next;
            o_Running <= (w_State_Next == RUN);
        end
    end

endmodule

// File: tb/tb_car_lane_mover.sv
// Self-checking bench: a right-moving and a left-moving car share one set of
// inputs and are compared every cycle against a countdown-based reference.
module tb_car_lane_mover;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       frz;
    logic [3:0] lvl;
    logic [9:0] xr, yr, xl, yl;
    logic       step_r, step_l, run_r, run_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: mode 0 parked, 1 moving, 2 held; 'left' counts down to the next step.
    int m_mode = 0;
    int m_left = 0;
    int m_xr   = 0;
    int m_xl   = 1;
    int m_step = 0;

    always #5 clk = ~clk;

    car_lane_mover #(
        .SCREEN_WIDTH(16), .START_X(0), .DIRECTION(1'b0), .STEP_PX(3),
        .BASE_TICKS(10), .LEVEL_DECREMENT(2), .MIN_TICKS(4)
    ) dut_r (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Freeze(frz), .i_Level(lvl),
        .o_Car_X(xr), .o_Car_Y(yr), .o_Step(step_r), .o_Running(run_r)
    );

    car_lane_mover #(
        .SCREEN_WIDTH(16), .START_X(1), .DIRECTION(1'b1), .STEP_PX(3),
        .BASE_TICKS(10), .LEVEL_DECREMENT(2), .MIN_TICKS(4)
    ) dut_l (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Freeze(frz), .i_Level(lvl),
        .o_Car_X(xl), .o_Car_Y(yl), .o_Step(step_l), .o_Running(run_l)
    );

    function automatic int period_of(input int level);
        int p;
        p = 10 - 2 * level;
        return (p < 4) ? 4 : p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_update();
        m_step = 0;
        if (rst) begin
            m_mode = 0; m_left = 0; m_xr = 0; m_xl = 1;
        end else if (m_mode == 0) begin
            m_xr = 0; m_xl = 1;
            if (en && !frz) begin
                m_mode = 1;
                m_left = period_of(int'(lvl));
            end
        end else if (!en) begin
            m_mode = 0; m_xr = 0; m_xl = 1;
        end else if (m_mode == 2) begin
            if (!frz) m_mode = 1;
        end else if (frz) begin
            m_mode = 2;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_step = 1;
                m_xr   = (m_xr + 3) % 16;
                m_xl   = (m_xl + 16 - 3) % 16;
                m_left = period_of(int'(lvl));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("model_xr", int'(xr), m_xr);
        check("model_xl", int'(xl), m_xl);
        check("model_yr", int'(yr), 320);
        check("model_yl", int'(yl), 320);
        check("model_step_r", int'(step_r), m_step);
        check("model_step_l", int'(step_l), m_step);
        check("model_run_r", int'(run_r), (m_mode == 1) ? 1 : 0);
        check("model_run_l", int'(run_l), (m_mode == 1) ? 1 : 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b1; en = 1'b0; frz = 1'b0; lvl = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit rst;
        bit en;
        bit frz;
        int lvl;
        int n;
        int xr;
        int xl;
        int step;
        int run;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int s;
        rst = 1'b1; en = 1'b0; frz = 1'b0; lvl = 4'd0;

        tbl.push_back('{1, 0, 0, 0,  2,  0,  1, 0, 0});
        tbl.push_back('{0, 1, 0, 0,  1,  0,  1, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 10,  3, 14, 1, 1});
        tbl.push_back('{0, 1, 0, 0, 10,  6, 11, 1, 1});
        tbl.push_back('{0, 1, 0, 0, 10,  9,  8, 1, 1});
        tbl.push_back('{0, 1, 0, 0, 10, 12,  5, 1, 1});
        tbl.push_back('{0, 1, 0, 0, 10, 15,  2, 1, 1});
        tbl.push_back('{0, 1, 0, 0, 10,  2, 15, 1, 1});
        tbl.push_back('{0, 1, 0, 0,  5,  2, 15, 0, 1});
        tbl.push_back('{0, 1, 0, 2,  5,  5, 12, 1, 1});
        tbl.push_back('{0, 1, 0, 2,  6,  8,  9, 1, 1});
        tbl.push_back('{0, 1, 0, 5,  6, 11,  6, 1, 1});
        tbl.push_back('{0, 1, 0, 5,  4, 14,  3, 1, 1});
        tbl.push_back('{0, 1, 0, 15, 4,  1,  0, 1, 1});
        tbl.push_back('{0, 1, 0, 15, 4,  4, 13, 1, 1});
        tbl.push_back('{0, 0, 0, 0,  1,  0,  1, 0, 0});

        foreach (tbl[k]) begin
            rst = tbl[k].rst; en = tbl[k].en; frz = tbl[k].frz; lvl = 4'(tbl[k].lvl);
            ticks(tbl[k].n);
            check($sformatf("tbl%0d_xr", k), int'(xr), tbl[k].xr);
            check($sformatf("tbl%0d_xl", k), int'(xl), tbl[k].xl);
            check($sformatf("tbl%0d_step", k), int'(step_r), tbl[k].step);
            check($sformatf("tbl%0d_run", k), int'(run_r), tbl[k].run);
        end

        // Freeze on the last tick of a period, hold 20 cycles, then resume.
        reset_pulse();
        en = 1'b1;
        ticks(10);
        frz = 1'b1;
        tick();
        check("frz_entry_step", int'(step_r), 0);
        check("frz_entry_x", int'(xr), 0);
        check("frz_entry_run", int'(run_r), 0);
        s = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            s += int'(step_r);
        end
        check("frz_hold_steps", s, 0);
        frz = 1'b0;
        tick();
        check("frz_resume_step", int'(step_r), 0);
        check("frz_resume_run", int'(run_r), 1);
        tick();
        check("frz_first_step", int'(step_r), 1);
        check("frz_first_x", int'(xr), 3);

        // Enable dropped while running at X=9, then while frozen.
        reset_pulse();
        en = 1'b1;
        ticks(31);
        check("drop_pre_x", int'(xr), 9);
        ticks(4);
        en = 1'b0;
        tick();
        check("drop_run_x", int'(xr), 0);
        check("drop_run_running", int'(run_r), 0);
        check("drop_run_step", int'(step_r), 0);
        en = 1'b1;
        tick();
        s = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            s += int'(step_r);
        end
        check("reen_early_steps", s, 0);
        tick();
        check("reen_step", int'(step_r), 1);
        check("reen_x", int'(xr), 3);
        frz = 1'b1;
        tick();
        check("drop_frz_pre_run", int'(run_r), 0);
        en = 1'b0;
        tick();
        check("drop_frz_x", int'(xr), 0);
        check("drop_frz_running", int'(run_r), 0);
        check("drop_frz_step", int'(step_r), 0);
        frz = 1'b0;
        ticks(2);
        check("drop_stay_idle", int'(run_r), 0);

        // Reset mid-period while frozen at X=12.
        reset_pulse();
        en = 1'b1;
        ticks(41);
        check("rst_pre_x", int'(xr), 12);
        ticks(3);
        frz = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rst_x", int'(xr), 0);
        check("rst_step", int'(step_r), 0);
        check("rst_run", int'(run_r), 0);
        check("rst_y", int'(yr), 320);
        rst = 1'b0;
        ticks(3);
        check("rst_after_run", int'(run_r), 0);
        check("rst_after_x", int'(xr), 0);

        // Randomized traffic against the reference.
        rst = 1'b0; en = 1'b1; frz = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 15) != 0);
            frz = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) lvl = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
